// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
// Segment codes are active-high {g,f,e,d,c,b,a} with bit 0 = segment a.
package seg7_scan_driver_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Indexed by hex nibble; the entry for F is leftmost in the concatenation.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        PH_DEAD = 1'b0,
        PH_LIT  = 1'b1
    } slot_phase_e;

    function automatic logic [6:0] seg_pol(input logic [6:0] seg, input bit act_low);
        return act_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between a result-register producer and the scan driver:
// load strobe with packed value/decimal points in, board-level pins out.
interface seg7_scan_driver_if #(
    parameter int N_DIGITS = 4
);
    logic                  load;
    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dp_in;
    logic [6:0]            seg;
    logic                  dp;
    logic [N_DIGITS-1:0]   an;
    logic                  frame_done;

    modport master (
        output load, value, dp_in,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  load, value, dp_in,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver_hex7_decoder.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex7_decoder
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit time-multiplexed seven-segment driver with anode dead-time,
// leading-zero blanking and frame-aligned display updates.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit AN_ACT_LOW  = 1'b1,
    parameter bit BLANK_LEAD  = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    seg7_scan_driver_if.slave bus_io
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int VAL_W = 4 * N_DIGITS;

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]          SEG_IDLE = seg_pol(SEG_OFF, SEG_ACT_LOW);
    localparam logic                DP_IDLE  = SEG_ACT_LOW;
    localparam logic [N_DIGITS-1:0] AN_IDLE  = AN_ACT_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [VAL_W-1:0]    pend_val_q, pend_val_d;
    logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                pend_flag_q, pend_flag_d;
    logic [VAL_W-1:0]    disp_val_q, disp_val_d;
    logic [N_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic                frame_done_q, frame_done_d;

    logic                slot_end;
    logic                frame_end;
    slot_phase_e         phase;
    logic [3:0]          nib;
    logic [6:0]          dec_seg;
    logic [N_DIGITS-1:0] zero_from;
    logic                blank;
    logic [6:0]          seg_raw;
    logic [N_DIGITS-1:0] an_raw;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    // Prescaler, digit index and the pending/display handover.
    always_comb begin
        cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_flag_d  = pend_flag_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        frame_done_d = frame_end;

        if (slot_end) begin
            idx_d = frame_end ? '0 : idx_q + 1'b1;
        end

        // A load landing on the wrap edge bypasses pending so no stale frame is shown.
        if (frame_end) begin
            if (bus_io.load) begin
                disp_val_d = bus_io.value;
                disp_dp_d  = bus_io.dp_in;
            end else if (pend_flag_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end
            pend_flag_d = 1'b0;
        end else if (bus_io.load) begin
            pend_val_d  = bus_io.value;
            pend_dp_d   = bus_io.dp_in;
            pend_flag_d = 1'b1;
        end
    end

    // zero_from[i] is set when nibbles N_DIGITS-1 down to i are all zero.
    always_comb begin
        logic run;
        run       = 1'b1;
        zero_from = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run          = run & (disp_val_q[4*i +: 4] == 4'h0);
            zero_from[i] = run;
        end
    end

    assign nib   = disp_val_q[4*int'(idx_q) +: 4];
    assign phase = (int'(cnt_q) >= DEAD_CYCLES) ? PH_LIT : PH_DEAD;
    assign blank = BLANK_LEAD && (idx_q != '0) && zero_from[idx_q];

    hex7_decoder u_dec (
        .nib_i (nib),
        .seg_o (dec_seg)
    );

    always_comb begin
        seg_raw = blank ? SEG_OFF : dec_seg;
        an_raw  = '0;
        if (phase == PH_LIT) begin
            an_raw[idx_q] = 1'b1;
        end
        seg_d = seg_pol(seg_raw, SEG_ACT_LOW);
        dp_d  = disp_dp_q[idx_q] ^ SEG_ACT_LOW;
        an_d  = AN_ACT_LOW ? ~an_raw : an_raw;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_flag_q  <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            seg_q        <= SEG_IDLE;
            dp_q         <= DP_IDLE;
            an_q         <= AN_IDLE;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_flag_q  <= pend_flag_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus_io.seg        = seg_q;
    assign bus_io.dp         = dp_q;
    assign bus_io.an         = an_q;
    assign bus_io.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: one default-parameter instance plus two fast-scan
// instances of opposite polarity driven identically and checked against a cycle model.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int DEAD  = 1;
    localparam int FRAME = RD * N;

    localparam logic [6:0] LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.N_DIGITS(4)) if_a ();
    seg7_scan_driver_if #(.N_DIGITS(4)) if_b ();
    seg7_scan_driver_if #(.N_DIGITS(4)) if_c ();

    seg7_scan_driver u_a (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus_io  (if_a)
    );

    seg7_scan_driver #(
        .N_DIGITS(4), .REFRESH_DIV(RD), .DEAD_CYCLES(DEAD),
        .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b1), .BLANK_LEAD(1'b1)
    ) u_b (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus_io  (if_b)
    );

    seg7_scan_driver #(
        .N_DIGITS(4), .REFRESH_DIV(RD), .DEAD_CYCLES(DEAD),
        .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b0), .BLANK_LEAD(1'b1)
    ) u_c (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus_io  (if_c)
    );

    int n_tests;
    int n_fail;

    // Model state: cycles since reset plus the frame-level view of the data.
    int          m_t;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_ddp, m_pdp;
    bit          m_flag;

    // Expected outputs after the next edge, active-high (model polarity).
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fd;

    function automatic logic [25:0] exp_vec();
        return {~e_an, e_seg, e_dp, e_fd, e_an, ~e_seg, ~e_dp, e_fd};
    endfunction

    function automatic logic [25:0] dut_vec();
        return {if_b.an, if_b.seg, if_b.dp, if_b.frame_done,
                if_c.an, if_c.seg, if_c.dp, if_c.frame_done};
    endfunction

    task automatic cyc(input bit rst, input bit ld, input logic [15:0] v, input logic [3:0] d);
        int idx, cnt;
        bit bnd;
        logic [15:0] upper;
        rst_n      = !rst;
        if_b.load  = ld;  if_b.value = v;  if_b.dp_in = d;
        if_c.load  = ld;  if_c.value = v;  if_c.dp_in = d;
        if (rst) begin
            e_an = '0; e_seg = 7'h00; e_dp = 1'b0; e_fd = 1'b0;
            m_t = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_flag = 1'b0;
        end else begin
            idx   = (m_t / RD) % N;
            cnt   = m_t % RD;
            bnd   = (m_t % FRAME) == FRAME - 1;
            upper = m_disp >> (4 * idx);
            e_an  = (cnt >= DEAD) ? 4'(1 << idx) : 4'h0;
            e_seg = (idx > 0 && upper == 16'h0) ? 7'h00 : LUT[upper[3:0]];
            e_dp  = m_ddp[idx];
            e_fd  = bnd;
            if (bnd) begin
                if (ld) begin
                    m_disp = v; m_ddp = d;
                end else if (m_flag) begin
                    m_disp = m_pend; m_ddp = m_pdp;
                end
                m_flag = 1'b0;
            end else if (ld) begin
                m_pend = v; m_pdp = d; m_flag = 1'b1;
            end
            m_t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0, 4'h0);
        n_tests++;
        if ({if_a.an, if_a.seg, if_a.dp, if_a.frame_done} !== {4'b1111, 7'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_default got an=%b seg=%h dp=%b fd=%b want an=1111 seg=00 dp=0 fd=0",
                     if_a.an, if_a.seg, if_a.dp, if_a.frame_done);
        end
        n_tests++;
        if (dut_vec() !== {4'b1111, 7'h00, 1'b0, 1'b0, 4'b0000, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_polarity got %h want %h", dut_vec(),
                     {4'b1111, 7'h00, 1'b0, 1'b0, 4'b0000, 7'h7F, 1'b1, 1'b0});
        end
    endtask

    task automatic test_scan();
        int fd_cnt, lit_cnt, s;
        logic [6:0] want;
        fd_cnt  = 0;
        lit_cnt = 0;
        cyc(1'b0, 1'b1, 16'h12AF, 4'h0);
        n_tests++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL scan_load t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(1'b0, 1'b0, 16'h0, 4'h0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL scan t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
            end
            if (if_b.frame_done === 1'b1) fd_cnt++;
            s = m_t - 1;
            if (s >= FRAME && s < 2 * FRAME && if_b.an !== 4'b1111) begin
                lit_cnt++;
                case (if_b.an)
                    4'b1110: want = 7'h71;
                    4'b1101: want = 7'h77;
                    4'b1011: want = 7'h5B;
                    4'b0111: want = 7'h06;
                    default: want = 7'hxx;
                endcase
                n_tests++;
                if (if_b.seg !== want) begin
                    n_fail++; $display("FAIL scan_digit an=%b got seg=%h want %h", if_b.an, if_b.seg, want);
                end
            end
        end
        n_tests++;
        if (fd_cnt !== 2) begin
            n_fail++; $display("FAIL scan_frame_done got %0d pulses want 2", fd_cnt);
        end
        n_tests++;
        if (lit_cnt !== 12) begin
            n_fail++; $display("FAIL scan_lit_cycles got %0d want 12", lit_cnt);
        end
    endtask

    task automatic test_blanking();
        cyc(1'b0, 1'b1, 16'h0005, 4'b0100);
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(1'b0, 1'b0, 16'h0, 4'h0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL blank t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
            end
            if (i >= FRAME && if_b.an !== 4'b1111) begin
                n_tests++;
                if (if_b.an == 4'b1011 && {if_b.seg, if_b.dp} !== {7'h00, 1'b1}) begin
                    n_fail++; $display("FAIL blank_d2 got seg=%h dp=%b want seg=00 dp=1", if_b.seg, if_b.dp);
                end else if (if_b.an == 4'b1110 && if_b.seg !== 7'h6D) begin
                    n_fail++; $display("FAIL blank_d0 got seg=%h want 6d", if_b.seg);
                end else if ((if_b.an == 4'b0111 || if_b.an == 4'b1101) && if_b.seg !== 7'h00) begin
                    n_fail++; $display("FAIL blank_lead an=%b got seg=%h want 00", if_b.an, if_b.seg);
                end
            end
        end
    endtask

    task automatic test_midframe_load();
        int f0, s;
        logic [6:0] want;
        cyc(1'b0, 1'b1, 16'h1111, 4'h0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(1'b0, 1'b0, 16'h0, 4'h0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL mid_pre t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
            end
        end
        for (int i = 0; i < FRAME && !(((m_t / RD) % N) == 1 && (m_t % RD) == 1); i++) begin
            cyc(1'b0, 1'b0, 16'h0, 4'h0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL mid_seek t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
            end
        end
        f0 = m_t / FRAME;
        cyc(1'b0, 1'b1, 16'h2222, 4'h0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(1'b0, 1'b0, 16'h0, 4'h0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL mid t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
            end
            s = m_t - 1;
            if (if_b.an !== 4'b1111) begin
                want = (s / FRAME == f0) ? 7'h06 : 7'h5B;
                n_tests++;
                if (if_b.seg !== want) begin
                    n_fail++; $display("FAIL mid_tear an=%b got seg=%h want %h", if_b.an, if_b.seg, want);
                end
            end
        end
    endtask

    task automatic test_boundary_load();
        logic [15:0] r1, r2;
        r1 = 16'($urandom);
        r2 = 16'($urandom);
        if (r2[3:0] == r1[3:0]) r2[3:0] = r1[3:0] + 4'h1;
        for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 5; i++) begin
            cyc(1'b0, 1'b0, 16'h0, 4'h0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL bnd_seek t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
            end
        end
        cyc(1'b0, 1'b1, r1, 4'h0);
        for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 1; i++) begin
            cyc(1'b0, 1'b0, 16'h0, 4'h0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL bnd_wait t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
            end
        end
        n_tests++;
        if ((m_t % FRAME) != FRAME - 1) begin
            n_fail++; $display("FAIL bnd_align got phase %0d want %0d", m_t % FRAME, FRAME - 1);
        end
        cyc(1'b0, 1'b1, r2, 4'h0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(1'b0, 1'b0, 16'h0, 4'h0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL bnd t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
            end
            if (if_b.an == 4'b1110) begin
                n_tests++;
                if (if_b.seg !== LUT[r2[3:0]]) begin
                    n_fail++; $display("FAIL bnd_d0 got seg=%h want %h", if_b.seg, LUT[r2[3:0]]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit ld;
        for (int i = 0; i < 300; i++) begin
            ld = ($urandom_range(0, 5) == 0);
            cyc(1'b0, ld, 16'($urandom), 4'($urandom));
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_polarity_reset();
        cyc(1'b0, 1'b1, 16'h0008, 4'h0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(1'b0, 1'b0, 16'h0, 4'h0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL pol t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
            end
            if (i >= FRAME && if_c.an == 4'b0001) begin
                n_tests++;
                if (if_c.seg !== 7'h00) begin
                    n_fail++; $display("FAIL pol_d0 got seg=%h want 00", if_c.seg);
                end
            end
        end
        for (int i = 0; i < FRAME && (m_t % FRAME) != RD + 1; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0);
        cyc(1'b0, 1'b1, 16'h3333, 4'hF);
        for (int i = 0; i < FRAME && (m_t % FRAME) != 2 * RD + 2; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0);
        n_tests++;
        if ((m_t % FRAME) != 2 * RD + 2) begin
            n_fail++; $display("FAIL rst_align got phase %0d want %0d", m_t % FRAME, 2 * RD + 2);
        end
        cyc(1'b1, 1'b0, 16'h0, 4'h0);
        n_tests++;
        if ({if_c.an, if_c.seg, if_c.dp, if_c.frame_done, if_b.an} !== {4'b0000, 7'h7F, 1'b1, 1'b0, 4'b1111}) begin
            n_fail++;
            $display("FAIL rst_mid got c_an=%b c_seg=%h c_dp=%b fd=%b b_an=%b want 0000 7f 1 0 1111",
                     if_c.an, if_c.seg, if_c.dp, if_c.frame_done, if_b.an);
        end
        cyc(1'b0, 1'b0, 16'h0, 4'h0);
        n_tests++;
        if (if_c.an !== 4'b0000) begin
            n_fail++; $display("FAIL rst_dead got an=%b want 0000", if_c.an);
        end
        cyc(1'b0, 1'b0, 16'h0, 4'h0);
        n_tests++;
        if ({if_c.an, if_c.seg} !== {4'b0001, 7'h40}) begin
            n_fail++; $display("FAIL rst_restart got an=%b seg=%h want 0001 40", if_c.an, if_c.seg);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(1'b0, 1'b0, 16'h0, 4'h0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rst_post t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        if_a.load = 1'b0; if_a.value = '0; if_a.dp_in = '0;
        if_b.load = 1'b0; if_b.value = '0; if_b.dp_in = '0;
        if_c.load = 1'b0; if_c.value = '0; if_c.dp_in = '0;
        m_t = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_flag = 1'b0;
        e_an = '0; e_seg = '0; e_dp = 1'b0; e_fd = 1'b0;
        #1;
        test_reset();
        test_scan();
        test_blanking();
        test_midframe_load();
        test_boundary_load();
        test_random();
        test_polarity_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
